// File: rtl/cpu_trace_monitor.sv
// ============================================================================
// Module   : cpu_trace_monitor
// Brief    : Circular PC/instruction trace buffer with PC trigger, post-trigger
//            window, optional halt (self-loop) detection and a registered read
//            port. Optional macro: TRACE_HALT_DETECT_EN builds the halt logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_trace_monitor #(
    parameter int ADDR_W      = 32,
    parameter int INST_W      = 32,
    parameter int DEPTH       = 16,
    parameter int POST_TRIG   = 4,
    parameter int HALT_REPEAT = 4,
    parameter int CNT_W       = 32,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              sample_en,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              trig_en,
    input  logic [ADDR_W-1:0] trig_pc,
    input  logic [PTR_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_pc,
    output logic [INST_W-1:0] rd_inst,
    output logic [PTR_W:0]    count,
    output logic              busy,
    output logic              done,
    output logic              trig_hit,
    output logic              halt,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_POST = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam int            c_POST_W    = $clog2(POST_TRIG + 2);
    localparam logic [PTR_W:0] c_DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W:0]      r_count;
    logic [CNT_W-1:0]    r_cycle;
    logic [c_POST_W-1:0] r_post_cnt;
    logic                r_trig_hit;
    logic [ADDR_W-1:0]   r_mem_pc   [DEPTH];
    logic [INST_W-1:0]   r_mem_inst [DEPTH];

    logic             w_busy;
    logic             w_wr_en;
    logic             w_trig;
    logic             w_post_end;
    logic             w_halt_fire;
    logic             w_stop;
    logic [PTR_W-1:0] w_rd_addr;
    logic             w_rd_valid;
    logic             w_rd_fwd;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_busy      = (r_state == c_ST_RUN) || (r_state == c_ST_POST);
        w_wr_en     = w_busy && sample_en && !arm;
        w_trig      = (r_state == c_ST_RUN) && trig_en && (pc_i == trig_pc) && sample_en && !arm;
        w_post_end  = (r_state == c_ST_POST) && w_wr_en && (r_post_cnt == c_POST_W'(1));
        w_stop      = (w_trig && (POST_TRIG == 0)) || w_post_end || w_halt_fire;
        w_state_nxt = r_state;
        if (arm)         w_state_nxt = c_ST_RUN;
        else if (w_stop) w_state_nxt = c_ST_DONE;
        else if (w_trig) w_state_nxt = c_ST_POST;
    end

    // Read address is relative to the oldest entry, using pre-edge pointer/count;
    // a same-edge write to that slot (full buffer, rd_idx 0) is forwarded.
    assign w_rd_addr  = r_wr_ptr - r_count[PTR_W-1:0] + rd_idx;
    assign w_rd_valid = ({1'b0, rd_idx} < r_count);
    assign w_rd_fwd   = w_wr_en && (w_rd_addr == r_wr_ptr);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_pc[r_wr_ptr]   <= pc_i;
            r_mem_inst[r_wr_ptr] <= inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_cycle    <= '0;
            r_post_cnt <= '0;
            r_trig_hit <= 1'b0;
            rd_pc      <= '0;
            rd_inst    <= '0;
        end else begin
            r_trig_hit <= w_trig;
            if (!w_rd_valid) begin
                rd_pc   <= '0;
                rd_inst <= '0;
            end else if (w_rd_fwd) begin
                rd_pc   <= pc_i;
                rd_inst <= inst_i;
            end else begin
                rd_pc   <= r_mem_pc[w_rd_addr];
                rd_inst <= r_mem_inst[w_rd_addr];
            end
            if (arm) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_cycle  <= '0;
            end else begin
                if (w_busy && (r_cycle != '1)) r_cycle <= r_cycle + 1'b1;
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (r_count != c_DEPTH_CNT) r_count <= r_count + 1'b1;
                end
                if (w_trig)
                    r_post_cnt <= c_POST_W'(POST_TRIG);
                else if ((r_state == c_ST_POST) && w_wr_en)
                    r_post_cnt <= r_post_cnt - 1'b1;
            end
        end
    end

`ifdef TRACE_HALT_DETECT_EN
    localparam int c_REP_W = $clog2(HALT_REPEAT + 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic [c_REP_W-1:0] w_rep_nxt;
    logic [ADDR_W-1:0]  r_last_pc;
    logic               r_halt;

    // A zero repeat count means no sample stored since arm, so no previous PC.
    assign w_rep_nxt   = ((r_rep_cnt != '0) && (pc_i == r_last_pc)) ? r_rep_cnt + 1'b1
                                                                    : c_REP_W'(1);
    assign w_halt_fire = w_wr_en && (w_rep_nxt == c_REP_W'(HALT_REPEAT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= '0;
            r_last_pc <= '0;
            r_halt    <= 1'b0;
        end else if (arm) begin
            r_rep_cnt <= '0;
            r_halt    <= 1'b0;
        end else if (w_wr_en) begin
            r_rep_cnt <= w_rep_nxt;
            r_last_pc <= pc_i;
            if (w_halt_fire) r_halt <= 1'b1;
        end
    end

    assign halt = r_halt;
`else
    assign w_halt_fire = 1'b0;
    assign halt        = 1'b0;
`endif

    assign count     = r_count;
    assign busy      = w_busy;
    assign done      = (r_state == c_ST_DONE);
    assign trig_hit  = r_trig_hit;
    assign cycle_cnt = r_cycle;

endmodule

`default_nettype wire

// File: tb/tb_cpu_trace_monitor.sv
// ============================================================================
// Module   : tb_cpu_trace_monitor
// Brief    : Directed plus randomized bench for cpu_trace_monitor, checked
//            every cycle against a queue-based trace model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_trace_monitor;

    localparam int ADDR_W      = 32;
    localparam int INST_W      = 32;
    localparam int DEPTH       = 16;
    localparam int POST_TRIG   = 4;
    localparam int HALT_REPEAT = 4;
    localparam int CNT_W       = 32;
    localparam int PTR_W       = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              arm;
    logic              sample_en;
    logic [ADDR_W-1:0] pc_i;
    logic [INST_W-1:0] inst_i;
    logic              trig_en;
    logic [ADDR_W-1:0] trig_pc;
    logic [PTR_W-1:0]  rd_idx;
    logic [ADDR_W-1:0] rd_pc;
    logic [INST_W-1:0] rd_inst;
    logic [PTR_W:0]    count;
    logic              busy;
    logic              done;
    logic              trig_hit;
    logic              halt;
    logic [CNT_W-1:0]  cycle_cnt;

    cpu_trace_monitor #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG),
        .HALT_REPEAT(HALT_REPEAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .sample_en(sample_en), .pc_i(pc_i),
        .inst_i(inst_i), .trig_en(trig_en), .trig_pc(trig_pc), .rd_idx(rd_idx),
        .rd_pc(rd_pc), .rd_inst(rd_inst), .count(count), .busy(busy), .done(done),
        .trig_hit(trig_hit), .halt(halt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    ent_t              q[$];
    bit                m_cap, m_post, m_done, m_halt, m_trig, m_have_prev;
    int                m_left, m_run;
    longint            m_cyc;
    logic [ADDR_W-1:0] m_prev;
    logic [ADDR_W-1:0] m_rdpc;
    logic [INST_W-1:0] m_rdinst;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Trace model: a bounded queue of stored samples plus capture flags.
    task automatic model_step();
        int n;
        bit wr, stop;
        if (rst) begin
            q.delete();
            m_cap = 0; m_post = 0; m_done = 0; m_halt = 0; m_trig = 0;
            m_cyc = 0; m_have_prev = 0; m_run = 0; m_left = 0;
            m_rdpc = '0; m_rdinst = '0;
            return;
        end
        n  = q.size();
        wr = m_cap && sample_en && !arm;
        if (int'(rd_idx) < n) begin
            if (wr && n == DEPTH && rd_idx == 0) begin
                m_rdpc = pc_i; m_rdinst = inst_i;
            end else begin
                m_rdpc = q[rd_idx].pc; m_rdinst = q[rd_idx].inst;
            end
        end else begin
            m_rdpc = '0; m_rdinst = '0;
        end
        m_trig = 0;
        if (arm) begin
            q.delete();
            m_cap = 1; m_post = 0; m_done = 0; m_halt = 0; m_cyc = 0;
            m_have_prev = 0; m_run = 0;
        end else if (m_cap) begin
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
            if (sample_en) begin
                ent_t e;
                e.pc = pc_i; e.inst = inst_i;
                q.push_back(e);
                if (q.size() > DEPTH) void'(q.pop_front());
                stop = 0;
                if (!m_post && trig_en && pc_i == trig_pc) begin
                    m_trig = 1;
                    if (POST_TRIG == 0) stop = 1;
                    else begin m_post = 1; m_left = POST_TRIG; end
                end else if (m_post) begin
                    m_left--;
                    if (m_left == 0) stop = 1;
                end
`ifdef TRACE_HALT_DETECT_EN
                m_run = (m_have_prev && pc_i == m_prev) ? m_run + 1 : 1;
                m_have_prev = 1;
                m_prev = pc_i;
                if (m_run == HALT_REPEAT) begin m_halt = 1; stop = 1; end
`endif
                if (stop) begin m_cap = 0; m_post = 0; m_done = 1; end
            end
        end
    endtask

    task automatic compare_all();
        chk("rd_pc",     64'(rd_pc),     64'(m_rdpc));
        chk("rd_inst",   64'(rd_inst),   64'(m_rdinst));
        chk("count",     64'(count),     64'(q.size()));
        chk("busy",      64'(busy),      64'(m_cap));
        chk("done",      64'(done),      64'(m_done));
        chk("trig_hit",  64'(trig_hit),  64'(m_trig));
        chk("halt",      64'(halt),      64'(m_halt));
        chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_in();
        rst = 0; arm = 0; sample_en = 0; rd_idx = '0;
    endtask

    task automatic sample(input logic [ADDR_W-1:0] pc);
        sample_en = 1; pc_i = pc; inst_i = pc ^ 32'hA5A5_0013;
        tick();
        sample_en = 0;
    endtask

    task automatic do_arm();
        arm = 1; tick(); arm = 0;
    endtask

    initial begin
        rst = 1; arm = 0; sample_en = 0; pc_i = '0; inst_i = '0;
        trig_en = 0; trig_pc = '0; rd_idx = '0;
        tick(); tick();
        chk("reset_count",  64'(count),     64'd0);
        chk("reset_busy",   64'(busy),      64'd0);
        chk("reset_done",   64'(done),      64'd0);
        chk("reset_rd_pc",  64'(rd_pc),     64'd0);
        chk("reset_cycle",  64'(cycle_cnt), 64'd0);
        idle_in();

        // Five samples, read back oldest, newest and out-of-range.
        do_arm();
        chk("arm_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 5; i++) sample(32'(i * 4));
        chk("five_count", 64'(count), 64'd5);
        rd_idx = 0; tick(); chk("five_rd0", 64'(rd_pc), 64'h00);
        chk("five_rd0_inst", 64'(rd_inst), 64'(32'h00 ^ 32'hA5A5_0013));
        rd_idx = 4; tick(); chk("five_rd4", 64'(rd_pc), 64'h10);
        rd_idx = 5; tick(); chk("five_rd5", 64'(rd_pc), 64'h00);
        rd_idx = 0;

        // Wrap: 20 samples into 16 entries, then 10 idle cycles.
        do_arm();
        for (int i = 0; i < 20; i++) sample(32'(i * 4));
        chk("wrap_count", 64'(count), 64'd16);
        rd_idx = 0;  tick(); chk("wrap_rd0",  64'(rd_pc), 64'h10);
        rd_idx = 15; tick(); chk("wrap_rd15", 64'(rd_pc), 64'h4C);
        rd_idx = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("idle_cycle", 64'(cycle_cnt), 64'd32);
        chk("idle_count", 64'(count), 64'd16);

        // Trigger at 0x20 with a 4-sample post window.
        do_arm();
        trig_en = 1; trig_pc = 32'h20;
        for (int i = 0; i <= 16; i++) begin
            sample(32'(i * 4));
            if (i == 8)  chk("trig_pulse", 64'(trig_hit), 64'd1);
            if (i == 9)  chk("trig_pulse_end", 64'(trig_hit), 64'd0);
            if (i == 11) chk("post_not_done", 64'(done), 64'd0);
            if (i == 12) chk("post_done", 64'(done), 64'd1);
        end
        chk("trig_count", 64'(count), 64'd13);
        rd_idx = 12; tick(); chk("trig_last", 64'(rd_pc), 64'h30);
        rd_idx = 0; trig_en = 0;

        // Self-loop halt.
        do_arm();
        sample(32'h08);
        for (int i = 0; i < 4; i++) begin
            sample(32'h0C);
            if (i == 2) chk("halt_early", 64'(halt), 64'd0);
        end
        chk("halt_count", 64'(count), 64'd5);
`ifdef TRACE_HALT_DETECT_EN
        chk("halt_set",  64'(halt), 64'd1);
        chk("halt_done", 64'(done), 64'd1);
`else
        chk("halt_off",  64'(halt), 64'd0);
        chk("halt_busy", 64'(busy), 64'd1);
`endif

        // Reset in POST, then arm from DONE.
        do_arm();
        trig_en = 1; trig_pc = 32'h20;
        sample(32'h1C); sample(32'h20); sample(32'h24);
        chk("post_busy", 64'(busy), 64'd1);
        rst = 1; arm = 1; tick(); rst = 0; arm = 0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_cycle", 64'(cycle_cnt), 64'd0);
        do_arm();
        for (int i = 0; i < 5; i++) sample(32'(32'h20 + i * 4));
        chk("done_again", 64'(done), 64'd1);
        do_arm();
        chk("rearm_count", 64'(count), 64'd0);
        chk("rearm_busy",  64'(busy),  64'd1);
        trig_en = 0;

        // Randomized traffic with a small PC pool to hit triggers and loops.
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            arm       = ($urandom_range(0, 39) == 0);
            sample_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) pc_i = 32'($urandom_range(0, 15)) << 2;
            inst_i    = $urandom;
            trig_en   = ($urandom_range(0, 1) == 1);
            trig_pc   = 32'h10;
            rd_idx    = PTR_W'($urandom_range(0, DEPTH - 1));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
